window_gen_3x3: RTL and testbench

// - Raster-to-window front end of the median filter: accepts one grayscale pixel per beat in raster order, buffers two lines, emits one 3x3 window per frame pixel.
// - Output taps px0..px8 feed the 9-input median selector directly; one window per cycle max, no output backpressure.

---
 rtl/window_gen_3x3_if.sv | 29 ++
 rtl/window_gen_3x3.sv | 178 +++++++++++++++++
 tb/tb_window_gen_3x3.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/window_gen_3x3_if.sv
// window_gen_3x3_if: handshake and tap bundle of the 3x3 window generator.
//   in_valid/in_sof/in_pixel : raster pixel stream into the generator
//   in_ready                 : generator can accept (beat = in_valid & in_ready)
//   out_valid/out_eof        : window valid / last window of the frame
//   px0..px8                 : window taps, row-major, px4 is the centre
// Modports: master drives the pixel stream, slave is the generator.
interface window_gen_3x3_if #(
    parameter int PIX_W = 8
);
    logic             in_valid;
    logic             in_sof;
    logic [PIX_W-1:0] in_pixel;
    logic             in_ready;
    logic             out_valid;
    logic             out_eof;
    logic [PIX_W-1:0] px0, px1, px2, px3, px4, px5, px6, px7, px8;

    modport master (
        output in_valid, in_sof, in_pixel,
        input  in_ready, out_valid, out_eof,
        input  px0, px1, px2, px3, px4, px5, px6, px7, px8
    );

    modport slave (
        input  in_valid, in_sof, in_pixel,
        output in_ready, out_valid, out_eof,
        output px0, px1, px2, px3, px4, px5, px6, px7, px8
    );
endinterface

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: raster-to-3x3-window front end of the median filter.
// Buffers two lines and emits one window per frame pixel; the window centred
// at index k-(IMG_W+1) leaves one cycle after input beat k, and the last
// IMG_W+1 windows are flushed with in_ready low.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : window_gen_3x3_if.slave (pixel stream in, window taps out)
// Optional build macro WINDOW_BORDER_REPLICATE_EN: out-of-frame taps take
// the nearest in-frame pixel; undefined, out-of-frame taps read 0.
module window_gen_3x3 #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 8
) (
    input logic             clk,
    input logic             rst,
    window_gen_3x3_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int FW = $clog2(IMG_W + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [FW-1:0] FL_LAST  = FW'(IMG_W);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t           state;
    logic             in_ready_q, out_valid_q, out_eof_q;
    logic [PIX_W-1:0] px_q [3][3];
    logic [CW-1:0]    col, ccol, rd_col;
    logic [RW-1:0]    row, crow;
    logic [FW-1:0]    fcnt;

    logic [PIX_W-1:0] lb0 [IMG_W];   // previous line
    logic [PIX_W-1:0] lb1 [IMG_W];   // line before that
    logic [PIX_W-1:0] raw     [3][3];
    logic [PIX_W-1:0] raw_nxt [3][3];
    logic [PIX_W-1:0] win     [3][3];
    logic [PIX_W-1:0] new_col [3];

    logic beat, start, accept, step, emit, last_beat;
    logic [2:0] row_in, col_in;

    assign beat      = bus.in_valid & in_ready_q;
    assign start     = beat & bus.in_sof;
    assign accept    = start | (beat & (state == RUN));
    assign rd_col    = start ? '0 : col;
    // During FLUSH the window keeps shifting with no input; the column that
    // enters is always outside the frame for the flushed centres and masked.
    assign step      = accept | (state == FLUSH);
    // Beat index k >= IMG_W+1 <=> row >= 2, or row 1 with col >= 1
    assign emit      = (state == FLUSH) |
                       (accept & ~start & (row != '0) & ((row != RW'(1)) | (col != '0)));
    assign last_beat = accept & ~start & (col == COL_LAST) & (row == ROW_LAST);

    assign new_col[0] = lb1[rd_col];
    assign new_col[1] = lb0[rd_col];
    assign new_col[2] = bus.in_pixel;

    assign raw_nxt[0] = '{raw[0][1], raw[0][2], new_col[0]};
    assign raw_nxt[1] = '{raw[1][1], raw[1][2], new_col[1]};
    assign raw_nxt[2] = '{raw[2][1], raw[2][2], new_col[2]};

    // Border status of the centre being emitted. At the column wrap the raw
    // left/right columns belong to other lines; they are exactly the ones
    // flagged here, so no data crosses a line or frame boundary.
    assign row_in = {crow != ROW_LAST, 1'b1, crow != '0};
    assign col_in = {ccol != COL_LAST, 1'b1, ccol != '0};

`ifdef WINDOW_BORDER_REPLICATE_EN
    logic [1:0] rs [3];
    logic [1:0] cs [3];

    always_comb begin
        rs = '{row_in[0] ? 2'd0 : 2'd1, 2'd1, row_in[2] ? 2'd2 : 2'd1};
        cs = '{col_in[0] ? 2'd0 : 2'd1, 2'd1, col_in[2] ? 2'd2 : 2'd1};
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                win[r][c] = raw_nxt[rs[r]][cs[c]];
            end
        end
    end
`else
    always_comb begin
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                win[r][c] = (row_in[r] && col_in[c]) ? raw_nxt[r][c] : '0;
            end
        end
    end
`endif

    // Line buffers and raw window carry no reset: stale contents only ever
    // reach masked taps.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[rd_col] <= lb0[rd_col];
            lb0[rd_col] <= bus.in_pixel;
        end
        if (step) begin
            raw <= raw_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_eof_q   <= 1'b0;
            px_q        <= '{default: '0};
            col         <= '0;
            row         <= '0;
            ccol        <= '0;
            crow        <= '0;
            fcnt        <= '0;
        end else begin
            out_valid_q <= emit;
            out_eof_q   <= emit & (crow == ROW_LAST) & (ccol == COL_LAST);
            if (emit) begin
                px_q <= win;
                if (ccol == COL_LAST) begin
                    ccol <= '0;
                    crow <= (crow == ROW_LAST) ? '0 : crow + 1'b1;
                end else begin
                    ccol <= ccol + 1'b1;
                end
            end
            case (state)
                IDLE, RUN: begin
                    if (start) begin
                        state <= RUN;
                        col   <= CW'(1);
                        row   <= '0;
                        ccol  <= '0;
                        crow  <= '0;
                    end else if (accept) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (last_beat) begin
                            state      <= FLUSH;
                            in_ready_q <= 1'b0;
                            fcnt       <= '0;
                        end
                    end
                end
                FLUSH: begin
                    col  <= (col == COL_LAST) ? '0 : col + 1'b1;
                    fcnt <= fcnt + 1'b1;
                    if (fcnt == FL_LAST) begin
                        state      <= IDLE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_eof   = out_eof_q;
    assign bus.px0 = px_q[0][0];
    assign bus.px1 = px_q[0][1];
    assign bus.px2 = px_q[0][2];
    assign bus.px3 = px_q[1][0];
    assign bus.px4 = px_q[1][1];
    assign bus.px5 = px_q[1][2];
    assign bus.px6 = px_q[2][0];
    assign bus.px7 = px_q[2][1];
    assign bus.px8 = px_q[2][2];
endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: scoreboard bench for window_gen_3x3 (IMG_W=4, IMG_H=3).
// The driver keeps a frame-level reference (pixel array indexed by raster
// position) and queues each expected window when the beat that completes it
// is accepted; a negedge monitor pops and compares every out_valid.
module tb_window_gen_3x3;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int PW = 8;
    localparam int N  = W * H;

    typedef struct packed {
        logic [9*PW-1:0] taps;
        logic            eof;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    window_gen_3x3_if #(.PIX_W(PW)) bus ();

    window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    win_t          exp_q[$];
    int            vectors     = 0;
    int            miscompares = 0;
    logic [PW-1:0] fr [N];
    int            k           = 0;
    bit            running     = 1'b0;
    int            flush_left  = 0;

    function automatic logic [PW-1:0] ref_tap(int r, int c);
`ifdef WINDOW_BORDER_REPLICATE_EN
        int rr = (r < 0) ? 0 : ((r >= H) ? H - 1 : r);
        int cc = (c < 0) ? 0 : ((c >= W) ? W - 1 : c);
        return fr[rr*W + cc];
`else
        if (r < 0 || r >= H || c < 0 || c >= W) return '0;
        return fr[r*W + c];
`endif
    endfunction

    task automatic push_win(input int ctr);
        win_t e;
        int   r = ctr / W;
        int   c = ctr % W;
        e.taps = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                e.taps = {e.taps[8*PW-1:0], ref_tap(r + dr, c + dc)};
            end
        end
        e.eof = (ctr == N - 1);
        exp_q.push_back(e);
    endtask

    // Reference behaviour of one accepted beat at frame level.
    task automatic model_beat(input logic s, input logic [PW-1:0] p);
        if (s) begin
            running = 1'b1;
            k = 0;
        end else if (!running) begin
            return;
        end else begin
            k++;
        end
        fr[k] = p;
        if (k >= W + 1) push_win(k - (W + 1));
        if (k == N - 1) begin
            for (int ctr = k - W; ctr < N; ctr++) push_win(ctr);
            running    = 1'b0;
            flush_left = W + 1;
        end
    endtask

    task automatic chk(input string name, input logic [9*PW-1:0] got, input logic [9*PW-1:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("reset_out_valid", 72'(bus.out_valid), 72'(0));
        chk("reset_out_eof", 72'(bus.out_eof), 72'(0));
        chk("reset_in_ready", 72'(bus.in_ready), 72'(1));
        chk("reset_taps", {bus.px0, bus.px1, bus.px2, bus.px3, bus.px4,
                           bus.px5, bus.px6, bus.px7, bus.px8}, '0);
    endtask

    // One clock of stimulus; acceptance follows the reference's in_ready.
    task automatic cycle(input logic v, input logic s, input logic [PW-1:0] p, output logic acc);
        logic exp_rdy;
        @(negedge clk);
        #1;
        bus.in_valid = v;
        bus.in_sof   = s;
        bus.in_pixel = p;
        exp_rdy = (flush_left == 0);
        chk("in_ready", 72'(bus.in_ready), 72'(exp_rdy));
        @(posedge clk);
        acc = v && exp_rdy;
        if (flush_left > 0) flush_left--;
        if (acc) model_beat(s, p);
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) cycle(1'b0, 1'b0, '0, acc);
    endtask

    task automatic send_beat(input logic s, input logic [PW-1:0] p);
        logic acc;
        acc = 1'b0;
        repeat (W + 3) begin
            if (!acc) cycle(1'b1, s, p, acc);
        end
    endtask

    // mode 0: pixel=k back-to-back; 1: pixel=k with bubbles; 2: random pixels
    task automatic send_frame(input int mode);
        for (int i = 0; i < N; i++) begin
            send_beat(i == 0, (mode == 2) ? PW'($urandom) : PW'(i));
            if (mode == 1) idle(1);
        end
    endtask

    always @(negedge clk) begin
        logic [9*PW-1:0] got;
        win_t            e;
        if (bus.out_valid) begin
            got = {bus.px0, bus.px1, bus.px2, bus.px3, bus.px4,
                   bus.px5, bus.px6, bus.px7, bus.px8};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_window: got taps=%h eof=%b, required no window",
                         got, bus.out_eof);
            end else begin
                e = exp_q.pop_front();
                if (got !== e.taps || bus.out_eof !== e.eof) begin
                    miscompares++;
                    $display("FAIL window: got taps=%h eof=%b, required taps=%h eof=%b",
                             got, bus.out_eof, e.taps, e.eof);
                end
            end
        end
    end

    initial begin
        logic acc;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pixel = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;

        send_frame(0);
        idle(W + 3);
        send_frame(1);
        idle(W + 3);

        // beats without sof while idle are dropped
        repeat (4) cycle(1'b1, 1'b0, PW'($urandom), acc);

        // abort with sof at beat 7, then a full random frame
        for (int i = 0; i < 7; i++) send_beat(i == 0, PW'(100 + i));
        send_frame(2);
        idle(W + 3);

        // reset while beat 8 is presented
        for (int i = 0; i < 8; i++) send_beat(i == 0, PW'(i));
        @(negedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sof   = 1'b0;
        bus.in_pixel = PW'(8);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk_reset_outputs();
        running    = 1'b0;
        flush_left = 0;
        exp_q.delete();
        rst = 1'b0;
        for (int i = 9; i < 14; i++) cycle(1'b1, 1'b0, PW'(i), acc);
        send_frame(0);

        // random traffic: bubbles, sof during run/flush, dropped idle beats
        for (int i = 0; i < 800; i++) begin
            logic v, s;
            v = ($urandom_range(0, 3) != 0);
            s = running ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
            cycle(v, s, PW'($urandom), acc);
        end

        // finish any open frame, then drain
        if (running) begin
            while (running) send_beat(1'b0, PW'($urandom));
        end
        idle(W + 8);
        chk("pending_windows", 72'(exp_q.size()), 72'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
